// File: rtl/write_ptr_ctrl.sv
// rtl/write_ptr_ctrl.sv - async FIFO write-side pointer, level and flag control (option: WRITE_PTR_OVERFLOW_EN)
module write_ptr_ctrl #(
    parameter int WIDTH_A     = 8,
    parameter int SYNC_STAGES = 2,
    parameter int AF_THRESH   = (1 << WIDTH_A) - 2
) (
    input  logic               w_clk,
    input  logic               w_rst,
    input  logic               w_req,
    input  logic [WIDTH_A:0]   r_gaddr,
    output logic               w_en,
    output logic [WIDTH_A-1:0] w_ram_addr,
    output logic [WIDTH_A:0]   w_addr,
    output logic [WIDTH_A:0]   w_gaddr,
    output logic               w_full,
    output logic               w_almost_full,
    output logic [WIDTH_A:0]   w_level,
    output logic               w_overflow,
    output logic [7:0]         w_drop_cnt
);

    localparam logic [WIDTH_A:0] DEPTH_L = {1'b1, {WIDTH_A{1'b0}}};
    localparam logic [WIDTH_A:0] AF_L    = (WIDTH_A + 1)'(AF_THRESH);

    logic [WIDTH_A:0] r_addr;
    logic [WIDTH_A:0] r_gaddr_q;
    logic [WIDTH_A:0] r_level;
    logic             r_full;
    logic             r_almost_full;
    logic [WIDTH_A:0] r_sync [SYNC_STAGES];

    logic [WIDTH_A:0] w_addr_nxt;
    logic [WIDTH_A:0] w_gaddr_nxt;
    logic [WIDTH_A:0] w_rd_bin;
    logic [WIDTH_A:0] w_level_nxt;
    logic             w_full_nxt;
    logic             w_af_nxt;

    function automatic logic [WIDTH_A:0] gray2bin(input logic [WIDTH_A:0] g);
        logic [WIDTH_A:0] b;
        for (int i = 0; i <= WIDTH_A; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    // Reset gates the RAM write so a request in a reset cycle never lands.
    assign w_en        = w_req & ~r_full & ~w_rst;
    assign w_addr_nxt  = r_addr + {{WIDTH_A{1'b0}}, w_en};
    assign w_gaddr_nxt = w_addr_nxt ^ (w_addr_nxt >> 1);
    assign w_rd_bin    = gray2bin(r_sync[SYNC_STAGES-1]);

    // Level is computed from the next write pointer so flags land on the same edge as the pointer.
    assign w_level_nxt = w_addr_nxt - w_rd_bin;
    assign w_full_nxt  = (w_level_nxt == DEPTH_L);
    assign w_af_nxt    = (w_level_nxt >= AF_L);

    // Read-pointer synchronizer chain; only single-bit Gray changes cross into this domain.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= r_gaddr;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // Write pointer, its Gray image and the occupancy flags all advance together.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_addr        <= '0;
            r_gaddr_q     <= '0;
            r_level       <= '0;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
        end else begin
            r_addr        <= w_addr_nxt;
            r_gaddr_q     <= w_gaddr_nxt;
            r_level       <= w_level_nxt;
            r_full        <= w_full_nxt;
            r_almost_full <= w_af_nxt;
        end
    end

    assign w_addr        = r_addr;
    assign w_gaddr       = r_gaddr_q;
    assign w_ram_addr    = r_addr[WIDTH_A-1:0];
    assign w_level       = r_level;
    assign w_full        = r_full;
    assign w_almost_full = r_almost_full;

`ifdef WRITE_PTR_OVERFLOW_EN
    logic       r_overflow;
    logic [7:0] r_drop_cnt;

    // Sticky overflow and saturating count of requests rejected while full.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= 8'd0;
        end else if (w_req && r_full) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != 8'hFF) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    assign w_overflow = r_overflow;
    assign w_drop_cnt = r_drop_cnt;
`else
    assign w_overflow = 1'b0;
    assign w_drop_cnt = 8'd0;
`endif

endmodule

// File: doc/write_ptr_ctrl.md
WRITE_PTR_CTRL -- requirements
Module: write_ptr_ctrl

Interface
REQ-001 Parameter WIDTH_A, default 8: address width; FIFO depth DEPTH = 2^WIDTH_A; legal range 2..16.
REQ-002 Parameter SYNC_STAGES, default 2: number of read-pointer synchronizer flops; legal range 2..4.
REQ-003 Parameter AF_THRESH, default 2^WIDTH_A-2: almost-full level; legal range 1..DEPTH.
REQ-004 w_clk  input  1  write-domain clock; sole clock; all flops rising-edge.
REQ-005 w_rst  input  1  synchronous, active-high reset.
REQ-006 w_req  input  1  write request.
REQ-007 r_gaddr  input  WIDTH_A+1  read pointer, Gray code, from read domain (asynchronous to w_clk).
REQ-008 w_en  output  1  RAM write enable = w_req & ~w_full (combinational).
REQ-009 w_ram_addr  output  WIDTH_A  RAM write address = w_addr[WIDTH_A-1:0].
REQ-010 w_addr  output  WIDTH_A+1  binary write pointer, registered.
REQ-011 w_gaddr  output  WIDTH_A+1  Gray write pointer, registered, to read domain.
REQ-012 w_full  output  1  FIFO full, registered.
REQ-013 w_almost_full  output  1  level >= AF_THRESH, registered.
REQ-014 w_level  output  WIDTH_A+1  occupancy as seen from write domain, 0..DEPTH, registered.
REQ-015 w_overflow  output  1  sticky overflow flag (see Configuration).
REQ-016 w_drop_cnt  output  8  saturating dropped-request count (see Configuration).

Function
REQ-017 Write accepted in a cycle iff w_en=1; on acceptance w_addr SHALL increment by 1 modulo 2^(WIDTH_A+1) at the next edge; otherwise hold.
REQ-018 w_gaddr SHALL equal bin2gray of w_addr in the same cycle, driven directly from a flop (gray of next pointer registered), never from combinational logic.
REQ-019 r_gaddr SHALL pass through SYNC_STAGES flops; the last stage is converted gray-to-binary (r_addr_sync).
REQ-020 Next level = w_addr_next - r_addr_sync, modulo 2^(WIDTH_A+1); w_level, w_full (next level == DEPTH) and w_almost_full (next level >= AF_THRESH) SHALL all register at the same edge as w_addr.
REQ-021 Latency: accepted write at edge n -> w_addr, w_gaddr, w_level, flags updated at edge n+1; a write is blocked in the cycle immediately after the one that fills the FIFO.
REQ-022 Latency: r_gaddr change -> reflected in w_level/w_full after SYNC_STAGES+1 edges.
REQ-023 Simultaneous accepted write and synchronized read advance in one cycle SHALL yield net level change (+1 - read delta) with no transient flag.
REQ-024 w_req while w_full=1 SHALL not modify w_addr, w_gaddr or RAM (w_en=0).
REQ-025 Pointer wrap (all-ones to zero) SHALL NOT produce a false full or level discontinuity; full is equivalently Gray pointers with top two bits inverted and remaining bits equal.

Reset
REQ-026 When w_rst=1 at an edge: w_addr=0, w_gaddr=0, all synchronizer stages=0, w_level=0, w_full=0, w_almost_full=0, w_overflow=0, w_drop_cnt=0.
REQ-027 Reset asserted mid-operation SHALL take priority over w_req in that cycle; w_en SHALL be 0 while w_rst=1.

Configuration
REQ-028 Macro WRITE_PTR_OVERFLOW_EN: when defined, w_req=1 with w_full=1 SHALL set w_overflow at the next edge (held until reset) and increment w_drop_cnt, saturating at 255.
REQ-029 When WRITE_PTR_OVERFLOW_EN is undefined, w_overflow and w_drop_cnt SHALL be constant 0 and no related flops SHALL be inferred.

Verification (WIDTH_A=3, SYNC_STAGES=2, AF_THRESH=6)
REQ-030 Hold w_rst=1 two cycles, w_req=1 -> all outputs 0, w_en=0, w_addr=0.
REQ-031 r_gaddr=0, w_req=1 nine cycles -> w_almost_full=1 after 6th write, w_full=1/w_level=8 after 8th, w_addr=4'b1000, w_gaddr=4'b1100, 9th request w_en=0.
REQ-032 From full, drive r_gaddr=4'b0011 (bin 2) -> w_full=0 and w_level=6 exactly 3 edges later, w_almost_full remains 1.
REQ-033 With macro defined, 3 requests while full -> w_overflow=1, w_drop_cnt=3; without macro both stay 0.
REQ-034 Concurrent writes and reads over 20 words -> w_addr wraps 4'b1111->4'b0000 (gray 1000->0000), w_full never asserts, w_level tracks reference model.
REQ-035 Assert w_rst at level 5 with w_req=1 -> next edge w_addr=0, w_level=0, w_full=0, w_en=0 during reset.
